// File: rtl/text_console_writer.sv
// Cursor-tracking byte writer for the text-mode screen/color RAMs: prints, interprets control codes,
// and clears a line on row advance or the full screen on reset/form feed.
module text_console_writer #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 25,
    parameter int          TAB_W      = 8,
    parameter logic [7:0]  CLEAR_CHR  = 8'h20,
    parameter logic [7:0]  CLEAR_COLR = 8'h07
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char_i,
    input  logic [7:0]  colr_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [11:0] addr_o,
    output logic [7:0]  chr_o,
    output logic [7:0]  colr_o,
    output logic        wren_ms_o,
    output logic        wren_mc_o,
    output logic [6:0]  cursor_x_o,
    output logic [4:0]  cursor_y_o
);

    // state      | meaning
    // IDLE       | accepting bytes, ready_o high
    // CLR_LINE   | blanking the row the cursor just moved onto
    // CLR_SCREEN | blanking every visible cell, row-major
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_LINE   = 2'd1,
        CLR_SCREEN = 2'd2
    } state_t;

    localparam logic [7:0] COLS_W    = 8'(COLS);
    localparam logic [7:0] COLS_END  = 8'(COLS - 1);
    localparam logic [6:0] COLS_LAST = 7'(COLS - 1);
    localparam logic [5:0] ROWS_W    = 6'(ROWS);
    localparam logic [4:0] ROWS_LAST = 5'(ROWS - 1);
    localparam logic [7:0] TAB_MASK  = 8'(TAB_W - 1);

    state_t      state, state_n;
    logic [5:0]  clr_row, clr_row_n;
    logic [7:0]  clr_col, clr_col_n;
    logic [6:0]  cur_x, cur_x_n;
    logic [4:0]  cur_y, cur_y_n;
    logic        ready_q;
    logic [11:0] addr_q, addr_n;
    logic [7:0]  chr_q, chr_n;
    logic [7:0]  colr_q, colr_n;
    logic        wren_q, wren_n;

    logic        accept;
    logic        is_bs, is_tab, is_lf, is_ff, is_cr, printable;
    logic [7:0]  tab_x;
    logic        row_adv;
    logic [4:0]  y_adv;
    logic        clr_done;

    assign accept    = valid_i && ready_q;
    assign is_bs     = (char_i == 8'h08);
    assign is_tab    = (char_i == 8'h09);
    assign is_lf     = (char_i == 8'h0A);
    assign is_ff     = (char_i == 8'h0C);
    assign is_cr     = (char_i == 8'h0D);
    assign printable = !(is_bs || is_tab || is_lf || is_ff || is_cr);
    assign tab_x     = ({1'b0, cur_x} | TAB_MASK) + 8'd1;
    assign row_adv   = is_lf || (printable && (cur_x == COLS_LAST)) || (is_tab && (tab_x >= COLS_W));
    assign y_adv     = (cur_y == ROWS_LAST) ? 5'd0 : cur_y + 5'd1;
    // Column counter runs one past the last cell so the final write and the return to IDLE are separate cycles.
    assign clr_done  = (state == CLR_LINE) ? (clr_col == COLS_W) : (clr_row == ROWS_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLR_SCREEN;
            clr_row <= '0;
            clr_col <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            chr_q   <= '0;
            colr_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state   <= state_n;
            clr_row <= clr_row_n;
            clr_col <= clr_col_n;
            cur_x   <= cur_x_n;
            cur_y   <= cur_y_n;
            ready_q <= (state_n == IDLE);
            addr_q  <= addr_n;
            chr_q   <= chr_n;
            colr_q  <= colr_n;
            wren_q  <= wren_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_ff)
                        state_n = CLR_SCREEN;
                    else if (row_adv)
                        state_n = CLR_LINE;
                end
            end
            CLR_LINE, CLR_SCREEN: begin
                if (clr_done)
                    state_n = IDLE;
            end
            default: state_n = CLR_SCREEN;
        endcase
    end

    always_comb begin
        cur_x_n   = cur_x;
        cur_y_n   = cur_y;
        clr_row_n = clr_row;
        clr_col_n = clr_col;
        addr_n    = addr_q;
        chr_n     = chr_q;
        colr_n    = colr_q;
        wren_n    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        addr_n = {cur_y, cur_x};
                        chr_n  = char_i;
                        colr_n = colr_i;
                        wren_n = 1'b1;
                        if (cur_x != COLS_LAST)
                            cur_x_n = cur_x + 7'd1;
                    end
                    if (is_cr)
                        cur_x_n = 7'd0;
                    if (is_bs && (cur_x != 7'd0))
                        cur_x_n = cur_x - 7'd1;
                    if (is_tab && !row_adv)
                        cur_x_n = tab_x[6:0];
                    if (is_ff) begin
                        cur_x_n   = 7'd0;
                        cur_y_n   = 5'd0;
                        clr_row_n = 6'd0;
                        clr_col_n = 8'd0;
                    end
                    if (row_adv) begin
                        cur_x_n   = 7'd0;
                        cur_y_n   = y_adv;
                        clr_row_n = {1'b0, y_adv};
                        clr_col_n = 8'd0;
                    end
                end
            end
            CLR_LINE: begin
                if (!clr_done) begin
                    addr_n    = {clr_row[4:0], clr_col[6:0]};
                    chr_n     = CLEAR_CHR;
                    colr_n    = CLEAR_COLR;
                    wren_n    = 1'b1;
                    clr_col_n = clr_col + 8'd1;
                end
            end
            CLR_SCREEN: begin
                if (!clr_done) begin
                    addr_n = {clr_row[4:0], clr_col[6:0]};
                    chr_n  = CLEAR_CHR;
                    colr_n = CLEAR_COLR;
                    wren_n = 1'b1;
                    if (clr_col == COLS_END) begin
                        clr_col_n = 8'd0;
                        clr_row_n = clr_row + 6'd1;
                    end else begin
                        clr_col_n = clr_col + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign ready_o    = ready_q;
    assign addr_o     = addr_q;
    assign chr_o      = chr_q;
    assign colr_o     = colr_q;
    assign wren_ms_o  = wren_q;
    assign wren_mc_o  = wren_q;
    assign cursor_x_o = cur_x;
    assign cursor_y_o = cur_y;

endmodule
